cor_sequencer: RTL
==================

# cor_sequencer

Sequences one acoustic measurement in the AD9226_CLK domain. Enforces a post-measurement holdoff, arms on the filtered channel-1 level, holds `start_cor` to the correlation shift/buffer/cor chain until `ready_offset`, then latches the signed offset and presents it to the UART transmit side with a valid/ack handshake. It replaces free-running trigger logic with a single resettable FSM that has an optional capture watchdog.

## Interface
- `AD9226_MSB`, 11 — MSB of the signed filtered sample.
- `offset_MSB`, 4 — MSB of the signed correlation offset.
- `HOLDOFF`, 625_000 — cycles spent in HOLDOFF before arming (Fs/2 at 1.25 MHz).
- `THRESHOLD`, 15 — signed trigger level; trigger when `sample > THRESHOLD`.
- `TIMEOUT`, 4096 — watchdog limit in CAPTURE, in cycles.
- `CNT_MSB`, 20 — MSB of the shared holdoff/watchdog counter; must hold max(HOLDOFF, TIMEOUT).
- `AD9226_CLK` in 1 — sample clock; all logic on its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `enable` in 1 — permits arming.
- `sample` in `AD9226_MSB+1` — signed filtered channel-1 sample.
- `ready_offset` in 1 — one-cycle pulse from the correlator; the result is valid in the same cycle.
- `offset_in` in `offset_MSB+1` — signed correlator result.
- `start_cor` out 1 — capture request to the correlation chain.
- `offset_out` out `offset_MSB+1` — latched signed offset.
- `offset_valid` out 1 — offset available to the UART side.
- `offset_ack` in 1 — consumer has taken `offset_out`.
- `busy` out 1 — high in CAPTURE or REPORT.
- `timeout_err` out 1 — sticky watchdog flag.
- `clear_err` in 1 — clears `timeout_err`.
- `meas_cnt` out 8 — completed-measurement counter.

## Operation
- FSM states: HOLDOFF, ARMED, CAPTURE, REPORT. Reset state is HOLDOFF with the counter at 0.
- HOLDOFF:
  - The counter increments each cycle while `enable`=1.
  - Counter == HOLDOFF-1 → ARMED, and the counter clears.
  - `enable`=0 clears the counter and holds the state.
- ARMED:
  - `enable`=0 → HOLDOFF with counter 0.
  - Else `$signed(sample) > $signed(THRESHOLD)` → CAPTURE. An equal value does not trigger.
- CAPTURE:
  - `start_cor`=1.
  - `ready_offset`=1 → latch `offset_in` into `offset_out`, go to REPORT, and increment `meas_cnt` (wraps 255→0).
  - `enable` is ignored; an active capture is never aborted by `enable`.
- REPORT:
  - `offset_valid`=1 and `offset_out` stay stable.
  - `offset_ack`=1 → HOLDOFF, counter 0.
- `ready_offset` outside CAPTURE is ignored. It does not change `offset_out` or `meas_cnt`.
- `timeout_err`:
  - Set on watchdog expiry (see Configuration).
  - Cleared by `clear_err`.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-operation returns to HOLDOFF and forces every output to its reset value. A `ready_offset` pending in the correlator is then ignored.

## Timing
- All outputs are registered. Reset values: `start_cor`=0, `offset_out`=0, `offset_valid`=0, `busy`=0, `timeout_err`=0, `meas_cnt`=0.
- Trigger:
  - The sample exceeds THRESHOLD in ARMED at edge N.
  - `start_cor`=1 and `busy`=1 from N+1.
- Completion:
  - `ready_offset` is sampled at edge M.
  - `start_cor`=0, `offset_valid`=1, and `offset_out` updated from M+1.
  - `meas_cnt` updates at M+1.
- Handshake:
  - `offset_ack` is sampled at edge K while `offset_valid`=1.
  - `offset_valid`=0 and `busy`=0 from K+1.
  - `offset_ack` with `offset_valid`=0 is ignored.
  - The offset is not overwritten until it has been acknowledged.
- Back-to-back:
  - The minimum spacing between trigger edges is HOLDOFF+1 cycles after the ack.
  - The first HOLDOFF cycle begins at K+1.

## Configuration
- `COR_SEQ_TIMEOUT_EN` defined:
  - The counter runs in CAPTURE.
  - If it reaches TIMEOUT-1 without `ready_offset`, the next state is HOLDOFF, `start_cor`=0, and `timeout_err` sets.
  - `offset_valid` and `meas_cnt` are unchanged.
  - If `ready_offset` arrives in the same cycle as expiry, completion wins and no error is flagged.
- Not defined:
  - CAPTURE waits indefinitely for `ready_offset`.
  - `timeout_err` is tied to 0.

## Test plan
Bench parameters: HOLDOFF=8, THRESHOLD=15, TIMEOUT=32.

- Reset, then `enable`=1 with `sample`=16 held → `start_cor` first rises exactly 10 edges after reset release (8 holdoff cycles, 1 arm cycle, 1 registered output); `busy`=1.
- In ARMED, apply `sample`=15, then -100, then 16 → no trigger on 15 or -100; `start_cor`=1 the cycle after 16.
- In CAPTURE, pulse `ready_offset` with `offset_in`=-7; hold `offset_ack`=0 for 20 cycles → `offset_out`=-7 and `offset_valid`=1 stable throughout; `meas_cnt`=1; a second `ready_offset` with `offset_in`=+3 is ignored.
- Pulse `offset_ack` → `offset_valid`=0 the next cycle; `enable`=0 during HOLDOFF holds the counter at 0; re-enable → 8 more cycles before ARMED.
- With `COR_SEQ_TIMEOUT_EN`, trigger and then withhold `ready_offset` → `start_cor` falls 32 cycles after rising, `timeout_err`=1, `meas_cnt` unchanged; `clear_err` → `timeout_err`=0. Without the macro → `start_cor` stays high for 1000 cycles.
- Assert `rst_n`=0 asynchronously mid-CAPTURE → all outputs drop to their reset values without a clock edge; after release the FSM restarts in HOLDOFF.

Source files
------------

// File: rtl/cor_sequencer.sv
// Measurement sequencer: holdoff, arm on filtered level, capture until the correlator reports, then hand the offset to the UART side.
// Optional capture watchdog enabled by defining COR_SEQ_TIMEOUT_EN.
module cor_sequencer #(
    parameter int AD9226_MSB = 11,
    parameter int offset_MSB = 4,
    parameter int HOLDOFF    = 625_000,
    parameter int THRESHOLD  = 15,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_MSB    = 20
) (
    input  logic                  AD9226_CLK,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [AD9226_MSB:0]   sample,
    input  logic                  ready_offset,
    input  logic [offset_MSB:0]   offset_in,
    output logic                  start_cor,
    output logic [offset_MSB:0]   offset_out,
    output logic                  offset_valid,
    input  logic                  offset_ack,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  clear_err,
    output logic [7:0]            meas_cnt
);

    localparam logic [1:0] S_HOLDOFF = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_REPORT  = 2'd3;

`ifdef COR_SEQ_TIMEOUT_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    localparam logic [CNT_MSB:0]           CNT_ZERO  = {(CNT_MSB+1){1'b0}};
    localparam logic [CNT_MSB:0]           CNT_ONE   = (CNT_MSB+1)'(1);
    localparam logic [CNT_MSB:0]           HOLD_LAST = (CNT_MSB+1)'(HOLDOFF - 1);
    localparam logic [CNT_MSB:0]           TO_LAST   = (CNT_MSB+1)'(TIMEOUT - 1);
    localparam logic signed [AD9226_MSB:0] THR_S     = (AD9226_MSB+1)'(THRESHOLD);

    logic [1:0]          state_q, state_d;
    logic [CNT_MSB:0]    cnt_q, cnt_d;
    logic [offset_MSB:0] offset_q, offset_d;
    logic [7:0]          meas_q, meas_d;
    logic                expire_q, expire_d;

    logic                start_cor_q, start_cor_d;
    logic [offset_MSB:0] offset_out_q, offset_out_d;
    logic                offset_valid_q, offset_valid_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic [7:0]          meas_cnt_q, meas_cnt_d;

    logic signed [AD9226_MSB:0] sample_s;
    assign sample_s = $signed(sample);

    // Next-state and shared counter; the counter restarts from zero on every state change.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        meas_d   = meas_q;
        expire_d = 1'b0;
        case (state_q)
            S_HOLDOFF: begin
                if (!enable) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_ARMED;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ARMED: begin
                if (!enable) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = CNT_ZERO;
                end else if (sample_s > THR_S) begin
                    state_d = S_CAPTURE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            S_CAPTURE: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (ready_offset) begin
                    offset_d = offset_in;
                    meas_d   = meas_q + 8'd1;
                    state_d  = S_REPORT;
                    cnt_d    = CNT_ZERO;
                end else if (WD_EN && (cnt_q == TO_LAST)) begin
                    state_d  = S_HOLDOFF;
                    cnt_d    = CNT_ZERO;
                    expire_d = 1'b1;
                end else if (WD_EN) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_REPORT: begin
                // Only an ack seen while the consumer can see the offset releases it.
                if (offset_ack && offset_valid_q) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            default: begin
                state_d = S_HOLDOFF;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output register stage, one edge behind the state it reflects.
    always_comb begin
        start_cor_d    = (state_q == S_CAPTURE);
        busy_d         = (state_q == S_CAPTURE) || (state_q == S_REPORT);
        offset_valid_d = (state_q == S_REPORT);
        offset_out_d   = offset_q;
        meas_cnt_d     = meas_q;
        if (expire_q) begin
            timeout_err_d = 1'b1;
        end else if (clear_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // State, counter and output flops.
    always_ff @(posedge AD9226_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_HOLDOFF;
            cnt_q          <= CNT_ZERO;
            offset_q       <= {(offset_MSB+1){1'b0}};
            meas_q         <= 8'd0;
            expire_q       <= 1'b0;
            start_cor_q    <= 1'b0;
            offset_out_q   <= {(offset_MSB+1){1'b0}};
            offset_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            meas_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            offset_q       <= offset_d;
            meas_q         <= meas_d;
            expire_q       <= expire_d;
            start_cor_q    <= start_cor_d;
            offset_out_q   <= offset_out_d;
            offset_valid_q <= offset_valid_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            meas_cnt_q     <= meas_cnt_d;
        end
    end

    assign start_cor    = start_cor_q;
    assign offset_out   = offset_out_q;
    assign offset_valid = offset_valid_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign meas_cnt     = meas_cnt_q;

endmodule
